// File: rtl/snippet_stim_checker.sv
// Stimulus generator and response checker for a small registered block under test.
// Each pass drives a flush, an 8-vector walk and a drain, and compares e/f against a shadow model.
`timescale 1ns/1ps

module snippet_stim_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       e,
    input  logic       f,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       mismatch,
    output logic [3:0] err_count,
    output logic [3:0] fail_idx
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] vec_idx;
    logic [2:0] vec_idx_next;
    logic [2:0] x_next;
    logic       me;
    logic       mf;
    logic       cmp_active;
    logic       cmp_fail;
    logic [3:0] cmp_idx;
    logic [3:0] err_next;
    logic       accept;

    // vec_idx doubles as the cycle counter for FLUSH and DRAIN as well as the RUN vector.
    always_comb begin
        state_next   = state;
        vec_idx_next = vec_idx + 3'd1;
        case (state)
            IDLE: begin
                vec_idx_next = 3'd0;
                if (start) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (vec_idx == 3'd1) begin
                    state_next   = RUN;
                    vec_idx_next = 3'd0;
                end
            end
            RUN: begin
                if (vec_idx == 3'd7) begin
                    state_next   = DRAIN;
                    vec_idx_next = 3'd0;
                end
            end
            DRAIN: begin
                if (vec_idx == 3'd1) begin
                    state_next   = DONE;
                    vec_idx_next = 3'd0;
                end
            end
            DONE: begin
                state_next   = IDLE;
                vec_idx_next = 3'd0;
            end
            default: begin
                state_next   = IDLE;
                vec_idx_next = 3'd0;
            end
        endcase
        x_next = (state_next == RUN) ? vec_idx_next : 3'b000;
    end

    assign accept     = (state == IDLE) && start;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign cmp_active = (state == RUN) || (state == DRAIN);
    assign cmp_idx    = (state == DRAIN) ? (4'd8 + {1'b0, vec_idx}) : {1'b0, vec_idx};

    // Case-inequality so that an unknown response from the block under test counts as a failure.
    assign cmp_fail   = cmp_active && ((e !== me) || (f !== mf));
    assign mismatch   = cmp_fail;
    assign err_next   = (cmp_fail && (err_count != 4'd10)) ? (err_count + 4'd1) : err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec_idx   <= 3'd0;
            x1        <= 1'b0;
            x2        <= 1'b0;
            x3        <= 1'b0;
            me        <= 1'b0;
            mf        <= 1'b0;
            err_count <= 4'd0;
            fail_idx  <= 4'hF;
            pass      <= 1'b0;
        end else begin
            state      <= state_next;
            vec_idx    <= vec_idx_next;
            {x1, x2, x3} <= x_next;
            if (accept) begin
                me        <= 1'b0;
                mf        <= 1'b0;
                err_count <= 4'd0;
                fail_idx  <= 4'hF;
                pass      <= 1'b0;
            end else begin
                mf        <= x1 & x2;
                me        <= x3 | mf;
                err_count <= err_next;
                if (cmp_fail && (fail_idx == 4'hF)) begin
                    fail_idx <= cmp_idx;
                end
                // The verdict is latched on the last DRAIN edge so it is already valid during DONE.
                if ((state == DRAIN) && (vec_idx == 3'd1)) begin
                    pass <= (err_next == 4'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_snippet_stim_checker.sv
// Directed bench for snippet_stim_checker with a behavioural block under test that can be
// switched between correct and faulty variants.
`timescale 1ns/1ps

module tb_snippet_stim_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       e;
    logic       f;
    logic       x1;
    logic       x2;
    logic       x3;
    logic       busy;
    logic       done;
    logic       pass;
    logic       mismatch;
    logic [3:0] err_count;
    logic [3:0] fail_idx;

    int checks;
    int passes;

    // 0 = correct, 1 = e stuck at 1, 2 = f stuck at 0, 3 = e inverted
    logic [2:0] butMode;
    logic       fB;
    logic       eB;
    logic       fOut;

    snippet_stim_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .e         (e),
        .f         (f),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .mismatch  (mismatch),
        .err_count (err_count),
        .fail_idx  (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural block under test: f <= x1&x2, e <= x3|f, with selectable faults.
    assign fOut = (butMode == 3'd2) ? 1'b0 : fB;
    always @(posedge clk) begin
        fB <= x1 & x2;
        eB <= x3 | fOut;
    end
    assign f = fOut;
    assign e = (butMode == 3'd1) ? 1'b1 : ((butMode == 3'd3) ? ~eB : eB);

    task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    // Runs one pass; cycle i is the sample #1 after the i-th edge following the start edge.
    task automatic applyStimulus(input int mode, input int pokeAt, output int latency,
                                 output logic [9:0] missMask, output logic [35:0] xSeq,
                                 output int stray, output logic [3:0] errAtFlush,
                                 output logic passAtFlush);
        butMode     = mode[2:0];
        latency     = 0;
        missMask    = '0;
        xSeq        = '0;
        stray       = 0;
        errAtFlush  = 4'h0;
        passAtFlush = 1'b0;
        for (int w = 0; w < 40 && busy; w++) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            start = (i == pokeAt);
            if (i == 1) begin
                errAtFlush  = err_count;
                passAtFlush = pass;
            end
            if (i <= 12) xSeq[(i-1)*3 +: 3] = {x1, x2, x3};
            if (mismatch) begin
                if (i >= 3 && i <= 12) missMask[i-3] = 1'b1;
                else stray++;
            end
            if (done) begin
                latency = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input int mode, input int pokeAt,
                               input logic [9:0] expMask, input logic [3:0] expErr,
                               input logic [3:0] expFail, input logic expPass);
        int         latency;
        int         stray;
        logic [9:0] missMask;
        logic [35:0] xSeq;
        logic [35:0] expX;
        logic [3:0] errAtFlush;
        logic       passAtFlush;
        expX = '0;
        for (int k = 0; k < 8; k++) expX[(k+2)*3 +: 3] = 3'(k);
        applyStimulus(mode, pokeAt, latency, missMask, xSeq, stray, errAtFlush, passAtFlush);
        checkOutput({tag, ".latency"}, 36'(latency), 36'd13);
        checkOutput({tag, ".xseq"}, xSeq, expX);
        checkOutput({tag, ".missmask"}, 36'(missMask), 36'(expMask));
        checkOutput({tag, ".stray"}, 36'(stray), 36'd0);
        checkOutput({tag, ".errflush"}, 36'(errAtFlush), 36'd0);
        checkOutput({tag, ".passflush"}, 36'(passAtFlush), 36'd0);
        checkOutput({tag, ".busydone"}, 36'(busy), 36'd1);
        checkOutput({tag, ".pass"}, 36'(pass), 36'(expPass));
        checkOutput({tag, ".errcount"}, 36'(err_count), 36'(expErr));
        checkOutput({tag, ".failidx"}, 36'(fail_idx), 36'(expFail));
    endtask

    initial begin
        int t1;
        int t2;
        checks  = 0;
        passes  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        butMode = 3'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset.x", 36'({x1, x2, x3}), 36'd0);
        checkOutput("reset.flags", 36'({busy, done, pass, mismatch}), 36'd0);
        checkOutput("reset.err", 36'(err_count), 36'd0);
        checkOutput("reset.failidx", 36'(fail_idx), 36'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        runAndCheck("good", 0, 0, 10'h000, 4'd0, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("good.idle", 36'({busy, done, pass}), 36'b001);

        runAndCheck("fstuck0", 2, 0, 10'h380, 4'd3, 4'd7, 1'b0);
        runAndCheck("estuck1", 1, 0, 10'h0AB, 4'd5, 4'd0, 1'b0);
        runAndCheck("einvert", 3, 0, 10'h3FF, 4'd10, 4'd0, 1'b0);
        runAndCheck("backtoback", 0, 0, 10'h000, 4'd0, 4'hF, 1'b1);

        runAndCheck("poke", 0, 6, 10'h000, 4'd0, 4'hF, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("poke.noqueue", 36'({busy, done}), 36'd0);

        // Reset asserted during RUN vector 4, then a fresh pass.
        butMode = 3'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrst.vec4", 36'({x1, x2, x3}), 36'b100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst.x", 36'({x1, x2, x3}), 36'd0);
        checkOutput("midrst.flags", 36'({busy, done, pass, mismatch}), 36'd0);
        checkOutput("midrst.err", 36'(err_count), 36'd0);
        checkOutput("midrst.failidx", 36'(fail_idx), 36'hF);
        runAndCheck("afterrst", 0, 0, 10'h000, 4'd0, 4'hF, 1'b1);

        // Start held high: one pass every 14 cycles.
        for (int w = 0; w < 40 && busy; w++) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        t1 = 0;
        t2 = 0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 60; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                if (t1 == 0) t1 = i;
                else if (t2 == 0) t2 = i;
            end
            if (t2 != 0) break;
        end
        start = 1'b0;
        checkOutput("held.first", 36'(t1), 36'd13);
        checkOutput("held.period", 36'(t2 - t1), 36'd14);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
